regbank_sequencer: RTL and testbench
====================================

# regbank_sequencer

Controller that shares the single-port 16×32 register bank between the decode stage (two-operand reads) and the writeback stage (one write). Each cycle it grants the bank's one `select`/`write` port to at most one operation, serializes the rs1 and rs2 reads, and gives writeback priority. It handles register x0 locally, with no port cycle. It sits between decode/writeback and the register bank, and owns the bank's `select`, `write` and `dataIn`.

## Interface

**Parameters**
- `DATA_W`, 32: register width.
- `NREGS`, 16: number of registers.
- `SEL_W`, $clog2(NREGS) = 4: register index width.

**Ports**
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `rd_req_valid` in 1: operand read request.
- `rd_req_ready` out 1: sequencer can accept a read request.
- `rs1_sel`, `rs2_sel` in SEL_W each: operand register indices.
- `rsp_valid` out 1: operand data valid.
- `rsp_ready` in 1: consumer accepts the operands.
- `rs1_data`, `rs2_data` out DATA_W each: operand values.
- `wb_valid` in 1: writeback request.
- `wb_ready` out 1: write buffer free.
- `wb_sel` in SEL_W: destination index.
- `wb_data` in DATA_W: value to write.
- `bank_select` out SEL_W: bank register select.
- `bank_write` out 1: bank write enable.
- `bank_data_in` out DATA_W: data driven to the bank.
- `bank_data_out` in DATA_W: bank read data, combinational from `bank_select`.

## Operation

- **Read FSM states:** IDLE, RD1, RD2, RESP.
- **IDLE:** `rd_req_ready`=1. On handshake, latch both sels and go to:
  - RD1 if rs1≠0;
  - else RD2 if rs2≠0;
  - else RESP.
- **RD1 / RD2:** when the port is granted to the read, drive `bank_select`=rs1 or rs2 and capture `bank_data_out` at the clock edge.
  - RD1 then goes to RD2 if rs2≠0, else RESP.
  - RD2 goes to RESP.
  - If the port is taken by a write, hold the state.
- **x0 reads:** an operand with index 0 is returned as 0 without a port cycle.
- **RESP:** `rsp_valid`=1, with data stable until the `rsp_ready` handshake, then IDLE. There is no new-request acceptance in RESP (no bypass from RESP to accept).
- **Write buffer:** one entry.
  - `wb_ready` = !buffer_valid.
  - A handshake with `wb_sel`≠0 loads the buffer.
  - A handshake with `wb_sel`=0 is accepted and discarded; the buffer is not loaded and no port cycle is used.
- **Port arbitration each cycle:**
  - If buffer_valid: write cycle. `bank_select`=buf_sel, `bank_write`=1, `bank_data_in`=buf_data, and the buffer clears at the edge.
  - Else if FSM is in RD1/RD2: read cycle.
  - Else idle port: `bank_select`=0, `bank_write`=0.
- **Ordering:** a read returns every write whose handshake completed before that read's port cycle. rs1 and rs2 may straddle a write (sequential semantics).
- **No starvation:** the buffer is busy during its drain cycle, so writes use at most every other cycle.
- **Reset:**
  - FSM goes to IDLE; buffer and latched operands are cleared (pending write dropped).
  - `rs1_data`, `rs2_data`, `bank_select`, `bank_data_in` = 0.
  - While `reset`=1, `rd_req_ready`, `wb_ready`, `rsp_valid` and `bank_write` are forced to 0.

## Timing

- **Read latency:** request handshake at cycle 0.
  - Both operands nonzero, no writes: RD1 at cycle 1, RD2 at cycle 2, `rsp_valid` at cycle 3.
  - One operand zero: `rsp_valid` at cycle 2.
  - Both operands zero: `rsp_valid` at cycle 1.
  - Each write cycle occurring while in RD1/RD2 adds 1 cycle.
- **Write latency:** handshake at cycle t; bank write at edge t+1 → t+2; `wb_ready` low during t+1.
- **Simultaneous events:** a write handshake in the same cycle as an RD1 read of the same register: the read sees the old value, and RD2 (if the same register) sees the new one.
- **Reset mid-operation:** asserted in any state, effective at the next edge; no partial response is ever presented.

## Structure

- **Shared package `regbank_pkg`:**
  - FSM state enum;
  - `DATA_W`, `NREGS`, `SEL_W` constants;
  - `X0_IDX` = 0.
- **Sub-module `regbank_wbuf`:** the one-entry write buffer (valid/sel/data, load, drain). Arbitration and the FSM stay in the top module.

## Test plan

- **Basic read:** write x3=0xDEADBEEF and x5=0x12345678, drained; then request rs1=3, rs2=5. Expect `rsp_valid` 3 cycles after the handshake with rs1_data=0xDEADBEEF and rs2_data=0x12345678, held under `rsp_ready`=0 for 4 cycles.
- **x0 handling:**
  - rs1=0, rs2=0: `rsp_valid` 1 cycle after the handshake, both data 0, no `bank_write`/select activity.
  - Write to x0 with 0xFFFFFFFF: `wb_ready` stays 1, no bank write, a later read of x0 returns 0.
- **Write priority:** request rs1=2, rs2=7, then present a write x7=0xA5A5A5A5 in the RD1 cycle. Expect the RD2 read delayed 1 cycle, rs2_data=0xA5A5A5A5, `rsp_valid` at cycle 4.
- **Back-to-back writes with a pending read:** keep `wb_valid` high every cycle. Expect writes on alternate cycles, the read completing, and `wb_ready` toggling 1/0.
- **Reset mid-read:** assert `reset` in RD2 with a buffered write to x4. Expect IDLE, `rsp_valid`=0, the x4 write not performed, and `rd_req_ready`=1 the cycle after `reset` drops.

Source files
------------

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants and read-FSM states for the register bank sequencer
package regbank_pkg;
  localparam int DATA_W = 32;
  localparam int NREGS = 16;
  localparam int SEL_W = $clog2(NREGS);
  localparam int X0_IDX = 0;
  typedef enum logic [1:0] {IDLE, RD1, RD2, RESP} rd_state_t;
endpackage

// File: rtl/regbank_wbuf.sv
// regbank_wbuf: one-entry write buffer; loads on a nonzero-index handshake, drains the following cycle
module regbank_wbuf #(
  parameter int DATA_W = regbank_pkg::DATA_W,
  parameter int SEL_W = regbank_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  output logic              buf_valid,
  output logic [SEL_W-1:0]  buf_sel,
  output logic [DATA_W-1:0] buf_data
);
  import regbank_pkg::*;
  assign wb_ready = !buf_valid && !reset;
  // a valid entry always owns the port, so it empties on the very next edge
  always_ff @(posedge clk)
    if (reset) begin
      buf_valid <= 1'b0;
      buf_sel <= '0;
      buf_data <= '0;
    end else if (wb_valid && wb_ready && wb_sel != SEL_W'(X0_IDX)) begin
      buf_valid <= 1'b1;
      buf_sel <= wb_sel;
      buf_data <= wb_data;
    end else
      buf_valid <= 1'b0;
endmodule

// File: rtl/regbank_sequencer.sv
// regbank_sequencer: shares the single-port register bank between two-operand reads and writeback,
// writes take priority and x0 is resolved locally without a port cycle
module regbank_sequencer #(
  parameter int DATA_W = regbank_pkg::DATA_W,
  parameter int NREGS = regbank_pkg::NREGS,
  parameter int SEL_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [SEL_W-1:0]  rs1_sel,
  input  logic [SEL_W-1:0]  rs2_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic [SEL_W-1:0]  bank_select,
  output logic              bank_write,
  output logic [DATA_W-1:0] bank_data_in,
  input  logic [DATA_W-1:0] bank_data_out
);
  import regbank_pkg::*;
  localparam logic [SEL_W-1:0] X0 = SEL_W'(X0_IDX);
  rd_state_t state, state_n;
  logic [SEL_W-1:0] rs1_q, rs2_q, buf_sel;
  logic [DATA_W-1:0] buf_data;
  logic buf_valid, accept, grant_rd, wr_cyc;
  regbank_wbuf #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_wbuf (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
    .wb_ready(wb_ready), .buf_valid(buf_valid), .buf_sel(buf_sel), .buf_data(buf_data)
  );
  assign rd_req_ready = state == IDLE && !reset;
  assign rsp_valid = state == RESP && !reset;
  assign accept = rd_req_valid && rd_req_ready;
  assign grant_rd = !buf_valid && (state == RD1 || state == RD2);
  assign wr_cyc = buf_valid && !reset;
  assign bank_write = wr_cyc;
  assign bank_data_in = wr_cyc ? buf_data : '0;
  assign bank_select = wr_cyc ? buf_sel : (grant_rd && !reset) ? (state == RD1 ? rs1_q : rs2_q) : X0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !accept ? IDLE : rs1_sel != X0 ? RD1 : rs2_sel != X0 ? RD2 : RESP;
      RD1: state_n = !grant_rd ? RD1 : rs2_q != X0 ? RD2 : RESP;
      RD2: state_n = grant_rd ? RESP : RD2;
      RESP: state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // operand data is zeroed on accept so skipped x0 operands read back as 0
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      rs1_q <= '0;
      rs2_q <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        rs1_q <= rs1_sel;
        rs2_q <= rs2_sel;
        rs1_data <= '0;
        rs2_data <= '0;
      end
      if (grant_rd && state == RD1) rs1_data <= bank_data_out;
      if (grant_rd && state == RD2) rs2_data <= bank_data_out;
    end
endmodule

// File: tb/tb_regbank_sequencer.sv
// tb_regbank_sequencer: directed and random stimulus; a monitor scores responses against a
// timeline model built from the logged write/read handshakes
module tb_regbank_sequencer;
  logic clk = 0, reset = 1;
  logic rd_req_valid = 0, rsp_ready = 0, wb_valid = 0;
  logic rd_req_ready, rsp_valid, wb_ready, bank_write;
  logic [3:0] rs1_sel = 0, rs2_sel = 0, wb_sel = 0, bank_select;
  logic [31:0] wb_data = 0, rs1_data, rs2_data, bank_data_in, bank_data_out;
  logic [31:0] mem [16];
  int cyc = 0, checks = 0, failures = 0, lastnz = -10;
  bit seen = 0;
  typedef struct {int c; logic [3:0] s; logic [31:0] d;} wr_t;
  typedef struct {int h; logic [3:0] s1; logic [3:0] s2;} rq_t;
  wr_t wlog[$];
  rq_t q[$];

  always #5 clk = ~clk;

  regbank_sequencer dut (
    .clk(clk), .reset(reset), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_sel(wb_sel), .wb_data(wb_data), .bank_select(bank_select), .bank_write(bank_write),
    .bank_data_in(bank_data_in), .bank_data_out(bank_data_out)
  );

  // the register bank itself: combinational read, write at the edge
  assign bank_data_out = mem[bank_select];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) for (int i = 0; i < 16; i++) mem[i] <= '0;
    else if (bank_write) mem[bank_select] <= bank_data_in;
  end

  function automatic void chk(string n, longint a, longint e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", n, cyc, a, e);
    end
  endfunction

  // a write handshaked at cycle c occupies the port at cycle c+1
  function automatic bit drained(input int c);
    for (int i = wlog.size() - 1; i >= 0; i--) begin
      if (wlog[i].c + 1 == c) return 1;
      if (wlog[i].c + 1 < c) break;
    end
    return 0;
  endfunction

  // register contents as seen by a port cycle p: every write handshaked strictly before p
  function automatic logic [31:0] value(input logic [3:0] s, input int p);
    if (s == 0) return '0;
    for (int i = wlog.size() - 1; i >= 0; i--)
      if (wlog[i].s == s && wlog[i].c < p) return wlog[i].d;
    return '0;
  endfunction

  function automatic void ports(input rq_t r, output int p1, output int p2, output int rc);
    int c = r.h;
    p1 = -1;
    p2 = -1;
    if (r.s1 != 0) begin
      c++;
      while (drained(c)) c++;
      p1 = c;
    end
    if (r.s2 != 0) begin
      c++;
      while (drained(c)) c++;
      p2 = c;
    end
    rc = c + 1;
  endfunction

  always @(negedge clk) begin
    int p1, p2, rc;
    bit ew;
    logic [3:0] es;
    if (reset) begin
      chk("rst_rd_req_ready", rd_req_ready, 0);
      chk("rst_wb_ready", wb_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_bank_write", bank_write, 0);
      if (wlog.size() > 0 && wlog[$].c == cyc - 1) void'(wlog.pop_back());
      lastnz = -10;
      q.delete();
      seen = 0;
    end else begin
      ew = lastnz == cyc - 1;
      chk("wb_ready", wb_ready, !ew);
      chk("bank_write", bank_write, ew);
      if (ew) begin
        chk("wr_select", bank_select, wlog[$].s);
        chk("wr_data", bank_data_in, wlog[$].d);
      end
      chk("rd_req_ready", rd_req_ready, q.size() == 0);
      es = '0;
      if (q.size() == 0) begin
        if (rsp_valid) chk("rsp_spurious", 1, 0);
      end else begin
        ports(q[0], p1, p2, rc);
        es = p1 == cyc ? q[0].s1 : p2 == cyc ? q[0].s2 : 4'd0;
        if (!seen && (rsp_valid || cyc >= rc)) begin
          chk("rsp_cycle", rsp_valid ? cyc : -1, rc);
          seen = rsp_valid;
          if (!rsp_valid) void'(q.pop_front());
        end
        if (seen) begin
          chk("rsp_valid_hold", rsp_valid, 1);
          chk("rs1_data", rs1_data, value(q[0].s1, p1));
          chk("rs2_data", rs2_data, value(q[0].s2, p2));
          if (!rsp_valid || rsp_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
      if (!ew) chk("rd_select", bank_select, es);
      if (wb_valid && wb_ready && wb_sel != 0) begin
        wlog.push_back(wr_t'{cyc, wb_sel, wb_data});
        lastnz = cyc;
      end
      if (rd_req_valid && rd_req_ready) q.push_back(rq_t'{cyc, rs1_sel, rs2_sel});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] s, input logic [31:0] d);
    bit ok = 0;
    wb_valid = 1;
    wb_sel = s;
    wb_data = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = wb_ready;
    end
    if (!ok) chk("wb_handshake_timeout", 0, 1);
    step();
    wb_valid = 0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] b, output int h);
    bit ok = 0;
    rd_req_valid = 1;
    rs1_sel = a;
    rs2_sel = b;
    h = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = rd_req_ready;
      h = cyc;
    end
    if (!ok) chk("rd_handshake_timeout", 0, 1);
    step();
    rd_req_valid = 0;
  endtask

  task automatic wait_rsp(output int at);
    at = -1;
    for (int i = 0; i < 40 && at < 0; i++) begin
      @(negedge clk);
      if (rsp_valid) at = cyc;
    end
    if (at < 0) chk("rsp_timeout", 0, 1);
  endtask

  task automatic accept();
    step();
    rsp_ready = 1;
    step();
    rsp_ready = 0;
  endtask

  function automatic logic [3:0] pick();
    return $urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom_range(1, 6));
  endfunction

  initial begin
    #300000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int h, at;
    bit r_prev, r_cur;
    repeat (3) step();
    chk("rst_rs1_data", rs1_data, 0);
    chk("rst_rs2_data", rs2_data, 0);
    chk("rst_bank_select", bank_select, 0);
    chk("rst_bank_data_in", bank_data_in, 0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_rd_ready", rd_req_ready, 1);
    chk("post_rst_wb_ready", wb_ready, 1);
    step();
    do_write(3, 32'hDEADBEEF);
    do_write(5, 32'h12345678);
    repeat (2) step();
    do_read(3, 5, h);
    wait_rsp(at);
    chk("basic_latency", at - h, 3);
    repeat (4) step();
    chk("basic_hold_valid", rsp_valid, 1);
    chk("basic_rs1", rs1_data, 32'hDEADBEEF);
    chk("basic_rs2", rs2_data, 32'h12345678);
    accept();
    do_read(0, 0, h);
    wait_rsp(at);
    chk("x0x0_latency", at - h, 1);
    chk("x0x0_rs1", rs1_data, 0);
    chk("x0x0_rs2", rs2_data, 0);
    accept();
    do_write(0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("x0_write_ready", wb_ready, 1);
    chk("x0_write_no_bank", bank_write, 0);
    step();
    do_read(0, 3, h);
    wait_rsp(at);
    chk("x0_one_latency", at - h, 2);
    chk("x0_read_rs1", rs1_data, 0);
    chk("x0_read_rs2", rs2_data, 32'hDEADBEEF);
    accept();
    do_read(2, 7, h);
    do_write(7, 32'hA5A5A5A5);
    wait_rsp(at);
    chk("prio_latency", at - h, 4);
    chk("prio_rs1", rs1_data, 0);
    chk("prio_rs2", rs2_data, 32'hA5A5A5A5);
    accept();
    fork
      begin
        int h2, at2;
        do_read(9, 10, h2);
        wait_rsp(at2);
        accept();
      end
      begin
        for (int i = 0; i < 12; i++) begin
          wb_valid = 1;
          wb_sel = 4'($urandom_range(1, 15));
          wb_data = $urandom;
          @(negedge clk);
          r_cur = wb_ready;
          if (i > 0) chk("wb_ready_toggle", r_cur, !r_prev);
          r_prev = r_cur;
          step();
        end
        wb_valid = 0;
      end
    join
    repeat (2) step();
    do_write(4, 32'h00000044);
    repeat (2) step();
    do_read(6, 8, h);
    do_write(4, 32'hBAD0BAD0);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_bank_write", bank_write, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    step();
    reset = 0;
    @(negedge clk);
    chk("mid_rst_rd_ready", rd_req_ready, 1);
    chk("mid_rst_no_rsp", rsp_valid, 0);
    step();
    step();
    chk("mid_rst_x4_kept", mem[4], 32'h00000044);
    do_read(4, 0, h);
    wait_rsp(at);
    chk("mid_rst_x4_read", rs1_data, 32'h00000044);
    accept();
    fork
      for (int i = 0; i < 1500; i++) begin
        step();
        wb_valid = $urandom_range(0, 2) != 0;
        wb_sel = 4'($urandom_range(0, 6));
        wb_data = $urandom;
      end
      for (int i = 0; i < 1500; i++) begin
        step();
        rd_req_valid = $urandom_range(0, 1) != 0;
        rs1_sel = pick();
        rs2_sel = pick();
        rsp_ready = $urandom_range(0, 3) != 0;
        reset = $urandom_range(0, 199) == 0;
      end
    join
    reset = 0;
    wb_valid = 0;
    rd_req_valid = 0;
    rsp_ready = 1;
    repeat (20) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
